// File: rtl/cdc_fifo_reader_pkg.sv
// Shared types and Gray-code helpers for the dual-clock FIFO read and write sides.
package cdc_fifo_reader_pkg;

   localparam int unsigned GRAY_FN_W = 32;

   // Read-side output register occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } rd_state_t;

   // Callers zero-extend into and truncate out of the fixed function width.
   function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] g);
      logic [GRAY_FN_W-1:0] b;
      b[GRAY_FN_W-1] = g[GRAY_FN_W-1];
      for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/cdc_fifo_reader_sync2.sv
// Two-flop synchronizer with synchronous reset; only the second stage is consumed.
module cdc_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         q     <= '0;
      end else begin
         sync1 <= d;
         q     <= sync1;
      end
   end

endmodule

// File: rtl/cdc_fifo_reader.sv
// Read-side controller of the dual-clock FIFO: synchronizes the Gray write pointer,
// owns the read pointer and presents memory words through a one-entry valid/ready register.
module cdc_fifo_reader
   import cdc_fifo_reader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_SIZE  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_SIZE:0]    w_ptr_gray,
   output logic [ADDR_SIZE:0]    r_ptr_gray,
   output logic [ADDR_SIZE-1:0]  r_addr,
   input  logic [DATA_WIDTH-1:0] r_mem_data,
   output logic                  r_valid,
   input  logic                  r_ready,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  r_empty,
   output logic [ADDR_SIZE:0]    r_fill
);

   localparam int unsigned PTR_W = ADDR_SIZE + 1;

   rd_state_t        state;
   rd_state_t        state_next;
   logic [PTR_W-1:0] w_sync2;
   logic [PTR_W-1:0] r_bin;
   logic [PTR_W-1:0] r_bin_inc;
   logic             load;

   cdc_sync2 #(.WIDTH(PTR_W)) u_wptr_sync (
      .clk   (clk),
      .reset (reset),
      .d     (w_ptr_gray),
      .q     (w_sync2)
   );

   // Gray compare is exact across laps because both pointers carry the lap MSB.
   assign r_empty   = (r_ptr_gray == w_sync2);
   assign r_fill    = PTR_W'(gray2bin(GRAY_FN_W'(w_sync2))) - r_bin;
   assign r_addr    = r_bin[ADDR_SIZE-1:0];
   assign r_bin_inc = r_bin + PTR_W'(1);
   assign load      = !r_empty && (!r_valid || r_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (load) begin
         state_next = ST_HOLD;
      end else if (state == ST_HOLD && r_ready) begin
         state_next = ST_EMPTY;
      end
   end

   always_comb begin
      r_valid = (state == ST_HOLD);
   end

   // Binary and Gray pointers advance together so the exported Gray value never glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin      <= '0;
         r_ptr_gray <= '0;
         r_data     <= '0;
      end else if (load) begin
         r_bin      <= r_bin_inc;
         r_ptr_gray <= PTR_W'(bin2gray(GRAY_FN_W'(r_bin_inc)));
         r_data     <= r_mem_data;
      end
   end

endmodule

// File: tb/tb_cdc_fifo_reader.sv
// Scoreboard bench for cdc_fifo_reader: directed pointer/memory stimulus, decoupled word monitor.
module tb_cdc_fifo_reader;

   localparam int unsigned DW = 8;
   localparam int unsigned AS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [AS:0]   w_ptr_gray;
   logic [AS:0]   r_ptr_gray;
   logic [AS-1:0] r_addr;
   logic [DW-1:0] r_mem_data;
   logic          r_valid;
   logic          r_ready;
   logic [DW-1:0] r_data;
   logic          r_empty;
   logic [AS:0]   r_fill;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] exp_q [$];
   int            errors = 0;
   int            checks = 0;
   int            acc_cnt = 0;

   cdc_fifo_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) dut (
      .clk        (clk),
      .reset      (reset),
      .w_ptr_gray (w_ptr_gray),
      .r_ptr_gray (r_ptr_gray),
      .r_addr     (r_addr),
      .r_mem_data (r_mem_data),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .r_data     (r_data),
      .r_empty    (r_empty),
      .r_fill     (r_fill)
   );

   assign r_mem_data = mem[r_addr];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_edge;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      drive_edge();
      reset      = 1'b1;
      w_ptr_gray = '0;
      r_ready    = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!r_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(r_valid), 32'd1);
   endtask

   // Monitor: pops one expected word per accepted transfer; checks hold stability under backpressure.
   initial begin
      logic          prev_hold;
      logic [DW-1:0] prev_data;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("hold_valid", 32'(r_valid), 32'd1);
               check("hold_data", 32'(r_data), 32'(prev_data));
            end
            if (r_valid && r_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_word: got 0x%0h expected no word", r_data);
               end else begin
                  check("word", 32'(r_data), 32'(exp_q.pop_front()));
               end
               acc_cnt++;
            end
            prev_hold = r_valid && !r_ready;
            prev_data = r_data;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic pat [10];
      int   acc0;
      int   n;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 16; i++) mem[i] = '0;
      reset      = 1'b1;
      w_ptr_gray = '0;
      r_ready    = 1'b0;

      // 1: reset state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(r_valid), 32'd0);
      check("rst_empty", 32'(r_empty), 32'd1);
      check("rst_gray", 32'(r_ptr_gray), 32'h0);
      check("rst_addr", 32'(r_addr), 32'h0);
      check("rst_fill", 32'(r_fill), 32'h0);
      check("rst_data", 32'(r_data), 32'h0);

      // 2: single word, stalled consumer, 3-edge latency
      drive_edge();
      mem[0]     = 8'hA5;
      w_ptr_gray = 5'h01;
      exp_q.push_back(8'hA5);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("lat2_valid", 32'(r_valid), 32'd0);
      check("lat2_fill", 32'(r_fill), 32'd1);
      check("lat2_empty", 32'(r_empty), 32'd0);
      @(negedge clk);
      for (int c = 0; c < 6; c++) begin
         check("single_valid", 32'(r_valid), 32'd1);
         check("single_data", 32'(r_data), 32'hA5);
         check("single_addr", 32'(r_addr), 32'd1);
         check("single_gray", 32'(r_ptr_gray), 32'h01);
         check("single_empty", 32'(r_empty), 32'd1);
         @(negedge clk);
      end
      drive_edge();
      r_ready = 1'b1;
      drive_edge();
      r_ready = 1'b0;
      @(negedge clk);
      check("single_drain", 32'(r_valid), 32'd0);

      // 3: full 16-word stream from a fresh reset
      do_reset(1);
      drive_edge();
      for (int i = 0; i < 16; i++) begin
         mem[i] = DW'(8'h10 + i);
         exp_q.push_back(DW'(8'h10 + i));
      end
      w_ptr_gray = 5'h18;
      r_ready    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("stream_fill16", 32'(r_fill), 32'd16);
      check("stream_pre_valid", 32'(r_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("stream_nogap", 32'(r_valid), 32'd1);
      end
      @(negedge clk);
      check("stream_end_valid", 32'(r_valid), 32'd0);
      check("stream_end_gray", 32'(r_ptr_gray), 32'h18);
      check("stream_end_fill", 32'(r_fill), 32'd0);

      // 4: second lap, pointer wraps 31 -> 0
      drive_edge();
      for (int i = 0; i < 16; i++) begin
         mem[i] = DW'(8'h20 + i);
         exp_q.push_back(DW'(8'h20 + i));
      end
      w_ptr_gray = 5'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("wrap_fill16", 32'(r_fill), 32'd16);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("wrap_nogap", 32'(r_valid), 32'd1);
         if (i == 14) begin
            check("wrap_gray31", 32'(r_ptr_gray), 32'h10);
            check("wrap_addr15", 32'(r_addr), 32'd15);
         end
         if (i == 15) begin
            check("wrap_gray0", 32'(r_ptr_gray), 32'h00);
            check("wrap_addr0", 32'(r_addr), 32'd0);
         end
      end
      @(negedge clk);
      check("wrap_end_valid", 32'(r_valid), 32'd0);
      check("wrap_end_empty", 32'(r_empty), 32'd1);

      // 5: backpressure over 8 words
      drive_edge();
      r_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mem[i] = DW'(8'h30 + i);
         exp_q.push_back(DW'(8'h30 + i));
      end
      w_ptr_gray = 5'h0C;
      acc0 = acc_cnt;
      wait_valid("bp_first_valid");
      for (int k = 0; k < 10; k++) begin
         drive_edge();
         r_ready = pat[k];
      end
      drive_edge();
      r_ready = 1'b1;
      n = 0;
      while ((acc_cnt - acc0) < 8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("bp_accepts", 32'(acc_cnt - acc0), 32'd8);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
      check("bp_gray", 32'(r_ptr_gray), 32'h0C);

      // 6: reset while a word is held
      drive_edge();
      r_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         mem[8+i] = DW'(8'h40 + i);
         exp_q.push_back(DW'(8'h40 + i));
      end
      w_ptr_gray = 5'h09;
      wait_valid("mid_valid");
      @(negedge clk);
      check("mid_fill5", 32'(r_fill), 32'd5);
      check("mid_data", 32'(r_data), 32'h40);
      drive_edge();
      reset      = 1'b1;
      w_ptr_gray = '0;
      drive_edge();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_valid", 32'(r_valid), 32'd0);
      check("mid_rst_gray", 32'(r_ptr_gray), 32'h0);
      check("mid_rst_addr", 32'(r_addr), 32'h0);
      check("mid_rst_fill", 32'(r_fill), 32'h0);
      check("mid_rst_empty", 32'(r_empty), 32'd1);
      repeat (3) @(negedge clk);
      check("post_rst_valid", 32'(r_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
